seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 174 +++++++++++++++++
 tb/tb_seg7_scan.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment scanner with staged, frame-synchronous data updates.
// Optional leading-zero blanking is compiled in with the SEG7_SCAN_LZB_EN macro.
module seg7_scan #(
    parameter int NDIGITS = 8,
    parameter int DIV     = 262144,
    parameter int GUARD   = 0
) (
    input  logic                   CLK100MHZ,
    input  logic                   reset,
    input  logic [4*NDIGITS-1:0]   data,
    input  logic [NDIGITS-1:0]     dp,
    input  logic                   load,
    output logic [6:0]             seg,
    output logic                   dpo,
    output logic [NDIGITS-1:0]     an,
    output logic                   frame,
    output logic                   pending
);

    localparam int PW = $clog2(DIV);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NDIGITS - 1);

    logic [PW-1:0]          r_pcnt;
    logic [IW-1:0]          r_idx;
    logic [4*NDIGITS-1:0]   r_shadow;
    logic [NDIGITS-1:0]     r_shadow_dp;
    logic [4*NDIGITS-1:0]   r_staging;
    logic [NDIGITS-1:0]     r_staging_dp;
    logic                   r_pending;
    logic [6:0]             r_seg;
    logic                   r_dpo;
    logic [NDIGITS-1:0]     r_an;
    logic                   r_frame;

    logic                   w_slot_end;
    logic                   w_frame_end;
    logic                   w_guard;
    logic [3:0]             w_nib;
    logic                   w_dp_sel;
    logic [NDIGITS-1:0]     w_an_sel;
    logic                   w_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_slot_end  = (r_pcnt == PCNT_MAX);
    assign w_frame_end = w_slot_end && (r_idx == IDX_MAX);

    // Prescaler and digit index: one slot of DIV cycles per digit.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_pcnt <= '0;
            r_idx  <= '0;
        end else if (w_slot_end) begin
            r_pcnt <= '0;
            r_idx  <= w_frame_end ? '0 : r_idx + IW'(1);
        end else begin
            r_pcnt <= r_pcnt + PW'(1);
        end
    end

    generate
        if (GUARD == 0) begin : g_no_guard
            assign w_guard = 1'b0;
        end else begin : g_guard
            assign w_guard = (r_pcnt < PW'(GUARD));
        end
    endgenerate

    // Selects the active digit's nibble, decimal point and anode pattern.
    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_nib    = 4'h0;
        w_dp_sel = 1'b0;
        w_an_sel = '1;
        for (int k = 0; k < NDIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_nib       = r_shadow[4*k +: 4];
                w_dp_sel    = r_shadow_dp[k];
                w_an_sel[k] = 1'b0;
            end
        end
    end

`ifdef SEG7_SCAN_LZB_EN
    // A digit blanks when it and every more-significant digit is zero with no dp.
    always_comb begin : lzb
        logic v_zero;
        w_blank = 1'b0;
        v_zero  = 1'b1;
        for (int k = NDIGITS - 1; k > 0; k--) begin
            v_zero = v_zero & (r_shadow[4*k +: 4] == 4'h0) & ~r_shadow_dp[k];
            if (r_idx == IW'(k)) begin
                w_blank = v_zero;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_seg   <= 7'h7F;
            r_dpo   <= 1'b1;
            r_an    <= '1;
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_blank ? 7'h7F : seg_decode(w_nib);
            r_dpo   <= w_blank | ~w_dp_sel;
            r_an    <= w_guard ? '1 : w_an_sel;
            r_frame <= w_frame_end;
        end
    end

    // Staging absorbs loads at any time; shadow only moves at a frame boundary
    // so a displayed frame never mixes old and new digits.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_shadow     <= '0;
            r_shadow_dp  <= '0;
            r_staging    <= '0;
            r_staging_dp <= '0;
            r_pending    <= 1'b0;
        end else if (load && w_frame_end) begin
            r_shadow     <= data;
            r_shadow_dp  <= dp;
            r_staging    <= data;
            r_staging_dp <= dp;
            r_pending    <= 1'b0;
        end else if (load) begin
            r_staging    <= data;
            r_staging_dp <= dp;
            r_pending    <= 1'b1;
        end else if (w_frame_end && r_pending) begin
            r_shadow     <= r_staging;
            r_shadow_dp  <= r_staging_dp;
            r_pending    <= 1'b0;
        end
    end

    assign seg     = r_seg;
    assign dpo     = r_dpo;
    assign an      = r_an;
    assign frame   = r_frame;
    assign pending = r_pending;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (4 digits, 4-cycle slots, 1 guard cycle);
// expected frames are queued when a load is driven and popped as the DUT scans.
module tb_seg7_scan;

    localparam int ND = 4;
    localparam int DV = 4;
    localparam int GD = 1;
    localparam int FL = ND * DV;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpo;
        logic       frame;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [6:0]  seg;
    logic        dpo;
    logic [3:0]  an;
    logic        frame;
    logic        pending;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   tb_cnt = 0;

    seg7_scan #(.NDIGITS(ND), .DIV(DV), .GUARD(GD)) dut (
        .CLK100MHZ(clk), .reset(reset), .data(data), .dp(dp), .load(load),
        .seg(seg), .dpo(dpo), .an(an), .frame(frame), .pending(pending));

    always #5 clk = ~clk;

    // Cycles since the last reset edge: the DUT's pcnt/idx state is tb_cnt mod FL.
    always @(posedge clk) tb_cnt <= reset ? 0 : tb_cnt + 1;

    // Expected outputs for cycle i of a frame showing digits d with points p.
    function automatic exp_t exp_at(int i, logic [15:0] d, logic [3:0] p);
        exp_t e;
        int slot;
        logic [3:0] nib;
        slot    = i / DV;
        nib     = d[slot*4 +: 4];
        e.an    = ((i % DV) < GD) ? 4'hF : ~(4'b0001 << slot);
        e.seg   = SEG_TAB[nib];
        e.dpo   = ~p[slot];
        e.frame = (i == FL - 1);
`ifdef SEG7_SCAN_LZB_EN
        begin
            logic blank;
            blank = (slot > 0);
            for (int k = slot; k < ND; k++)
                if (d[k*4 +: 4] != 4'h0 || p[k]) blank = 1'b0;
            if (blank) begin
                e.seg = 7'h7F;
                e.dpo = 1'b1;
            end
        end
`endif
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] p);
        for (int i = 0; i < FL; i++) sb_q.push_back(exp_at(i, d, p));
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] p);
        data = d;
        dp   = p;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic goto(input int target);
        int n = 0;
        while ((tb_cnt % FL) != target && n < 3 * FL) begin
            step();
            n++;
        end
        if ((tb_cnt % FL) != target) begin
            n_total++;
            $display("FAIL goto: phase %0d, wanted %0d", tb_cnt % FL, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load  = 1'b1;
        data  = 16'hFFFF;
        dp    = 4'hF;
        step();
        step();
        n_total++;
        if ({an, seg, dpo, frame, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_state: an=%h seg=%h dpo=%b frame=%b pend=%b, want F 7f 1 0 0",
                     an, seg, dpo, frame, pending);
        else n_pass++;
        reset = 1'b0;
        load  = 1'b0;
        step();
        n_total++;
        if ({an, seg, dpo, pending} !== {4'hF, 7'h40, 1'b1, 1'b0})
            $display("FAIL reset_first_guard: an=%h seg=%h dpo=%b pend=%b, want F 40 1 0",
                     an, seg, dpo, pending);
        else n_pass++;
        step();
        n_total++;
        if ({an, seg, dpo} !== {4'hE, 7'h40, 1'b1})
            $display("FAIL reset_digit0: an=%h seg=%h dpo=%b, want E 40 1", an, seg, dpo);
        else n_pass++;
    endtask

    task automatic test_load_display();
        exp_t got, e;
        goto(5);
        push_frame(16'h12AF, 4'b0100);
        load_word(16'h12AF, 4'b0100);
        n_total++;
        if (pending !== 1'b1) $display("FAIL load_pending_set: got %b want 1", pending);
        else n_pass++;
        goto(FL - 1);
        e = exp_at(FL - 2, 16'h0000, 4'h0);
        n_total++;
        if (pending !== 1'b1 || seg !== e.seg)
            $display("FAIL load_wait: pend=%b seg=%h, want 1 %h", pending, seg, e.seg);
        else n_pass++;
        step();
        n_total++;
        if (frame !== 1'b1 || pending !== 1'b0)
            $display("FAIL load_boundary: frame=%b pend=%b, want 1 0", frame, pending);
        else n_pass++;
        for (int i = 0; i < FL; i++) begin
            step();
            got = {an, seg, dpo, frame};
            e   = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            n_total++;
            if (got !== e)
                $display("FAIL load_display[%0d]: got %h want %h", i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_overwrite();
        exp_t got, e;
        goto(3);
        push_frame(16'h1111, 4'h0);
        load_word(16'h1111, 4'h0);
        n_total++;
        if (pending !== 1'b1) $display("FAIL ovw_pending1: got %b want 1", pending);
        else n_pass++;
        goto(8);
        sb_q.delete();
        push_frame(16'h2222, 4'h0);
        load_word(16'h2222, 4'h0);
        n_total++;
        if (pending !== 1'b1) $display("FAIL ovw_pending2: got %b want 1", pending);
        else n_pass++;
        goto(0);
        e = exp_at(FL - 1, 16'h12AF, 4'b0100);
        n_total++;
        if (pending !== 1'b0 || seg !== e.seg)
            $display("FAIL ovw_old_frame: pend=%b seg=%h, want 0 %h", pending, seg, e.seg);
        else n_pass++;
        for (int i = 0; i < FL; i++) begin
            step();
            got = {an, seg, dpo, frame};
            e   = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            n_total++;
            if (got !== e)
                $display("FAIL ovw_display[%0d]: got %h want %h", i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_boundary_load();
        exp_t got, e;
        goto(FL - 1);
        push_frame(16'h0005, 4'h0);
        load_word(16'h0005, 4'h0);
        n_total++;
        if (pending !== 1'b0 || frame !== 1'b1)
            $display("FAIL bnd_pending: pend=%b frame=%b, want 0 1", pending, frame);
        else n_pass++;
        for (int i = 0; i < FL; i++) begin
            step();
            got = {an, seg, dpo, frame};
            e   = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            n_total++;
            if (got !== e)
                $display("FAIL bnd_display[%0d]: got %h want %h", i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midslot();
        exp_t got, e;
        goto(5);
        load_word(16'h9876, 4'b0001);
        n_total++;
        if (pending !== 1'b1) $display("FAIL rst_mid_pending: got %b want 1", pending);
        else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++;
        if ({an, seg, dpo, frame, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0})
            $display("FAIL rst_mid_state: an=%h seg=%h dpo=%b frame=%b pend=%b, want F 7f 1 0 0",
                     an, seg, dpo, frame, pending);
        else n_pass++;
        push_frame(16'h0000, 4'h0);
        for (int i = 0; i < FL; i++) begin
            step();
            got = {an, seg, dpo, frame};
            e   = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            n_total++;
            if (got !== e)
                $display("FAIL rst_mid_display[%0d]: got %h want %h", i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_lzb();
        exp_t got, e;
        logic [15:0] d_tab [2] = '{16'h0030, 16'h0000};
        logic [3:0]  p_tab [2] = '{4'b0000, 4'b0100};
        for (int t = 0; t < 2; t++) begin
            goto(4);
            push_frame(d_tab[t], p_tab[t]);
            load_word(d_tab[t], p_tab[t]);
            goto(0);
            for (int i = 0; i < FL; i++) begin
                step();
                got = {an, seg, dpo, frame};
                e   = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
                n_total++;
                if (got !== e)
                    $display("FAIL lzb%0d[%0d]: got %h want %h", t, i, got, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, e;
        logic [15:0] d1, d2;
        logic [3:0]  p2;
        for (int t = 0; t < 4; t++) begin
            d1 = 16'($urandom);
            d2 = 16'($urandom);
            p2 = 4'($urandom_range(0, 15));
            goto($urandom_range(1, FL - 3));
            load_word(d1, 4'hF);
            push_frame(d2, p2);
            load_word(d2, p2);
            goto(0);
            for (int i = 0; i < FL; i++) begin
                step();
                got = {an, seg, dpo, frame};
                e   = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
                n_total++;
                if (got !== e)
                    $display("FAIL b2b%0d[%0d]: got %h want %h", t, i, got, e);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_display();
        test_overwrite();
        test_boundary_load();
        test_reset_midslot();
        test_lzb();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
